// File: rtl/csr_regfile.sv
// Machine-mode CSR storage (mepc, mcause, mtvec, mstatus, mie, mip) at the end of the
// writeback CSR bus, with MTIP tracking, a registered timer-interrupt request and hardware trap entry.
module csr_regfile #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [7:0]      wbcsren,
    input  logic [XLEN-1:0] wbmepc,
    input  logic [XLEN-1:0] wbmcause,
    input  logic [XLEN-1:0] wbmtvec,
    input  logic [XLEN-1:0] wbmstatus,
    input  logic [XLEN-1:0] wbmie,
    input  logic [XLEN-1:0] wbmip,
    input  logic            timer_irq,
    input  logic            irq_take,
    input  logic [XLEN-1:0] irq_pc,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mie,
    output logic [XLEN-1:0] mip,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_vector
);

    localparam logic [XLEN-1:0] MCAUSE_MTI = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

    typedef enum logic {IDLE, REQ} irq_state_e;

    irq_state_e      state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mip_q, mip_d;
    logic [5:0]      wr;
    logic            pend;
    logic            unused_rsvd;

    // Bits that are masked off or reserved and therefore never stored.
    assign unused_rsvd = ^{wbcsren[7:6], wbmepc[0], wbmtvec[1:0], irq_pc[0]};

    assign wr   = wbcsren[5:0] & {6{wb_valid}};
    assign pend = mstatus_q[3] & mie_q[7] & mip_q[7];

    always_comb begin
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtvec_d   = mtvec_q;
        mstatus_d = mstatus_q;
        mie_d     = mie_q;
        mip_d     = mip_q;
        if (wr[0]) mepc_d    = {wbmepc[XLEN-1:1], 1'b0};
        if (wr[1]) mcause_d  = wbmcause;
        if (wr[2]) mtvec_d   = {wbmtvec[XLEN-1:2], 2'b00};
        if (wr[3]) mstatus_d = wbmstatus;
        if (wr[4]) mie_d     = wbmie;
        if (wr[5]) mip_d     = wbmip;
        mip_d[7] = timer_irq;
        // Trap entry overrides any same-cycle bus write to mepc/mcause/mstatus.
        if (irq_take) begin
            mepc_d             = {irq_pc[XLEN-1:1], 1'b0};
            mcause_d           = MCAUSE_MTI;
            mstatus_d          = mstatus_q;
            mstatus_d[7]       = mstatus_q[3];
            mstatus_d[3]       = 1'b0;
            mstatus_d[12:11]   = 2'b11;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend && !irq_take) state_d = REQ;
            REQ:     if (irq_take || !pend) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtvec_q   <= '0;
            mstatus_q <= MSTATUS_RST;
            mie_q     <= '0;
            mip_q     <= '0;
        end else begin
            state_q   <= state_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtvec_q   <= mtvec_d;
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mip_q     <= mip_d;
        end
    end

    assign mepc       = mepc_q;
    assign mcause     = mcause_q;
    assign mtvec      = mtvec_q;
    assign mstatus    = mstatus_q;
    assign mie        = mie_q;
    assign mip        = mip_q;
    assign irq_req    = (state_q == REQ);
    assign irq_vector = {mtvec_q[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboarded bench for csr_regfile: directed scenarios then random traffic against a rule-level model.
module tb_csr_regfile;

    localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;

    typedef struct packed {
        logic [63:0] mepc, mcause, mtvec, mstatus, mie, mip;
        logic        req;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [7:0]  wbcsren = '0;
    logic [63:0] wbmepc = '0, wbmcause = '0, wbmtvec = '0, wbmstatus = '0, wbmie = '0, wbmip = '0;
    logic        timer_irq = 1'b0;
    logic        irq_take = 1'b0;
    logic [63:0] irq_pc = '0;
    logic [63:0] mepc, mcause, mtvec, mstatus, mie, mip, irq_vector;
    logic        irq_req;

    csr_regfile dut (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wbcsren(wbcsren),
        .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec), .wbmstatus(wbmstatus),
        .wbmie(wbmie), .wbmip(wbmip), .timer_irq(timer_irq), .irq_take(irq_take),
        .irq_pc(irq_pc), .mepc(mepc), .mcause(mcause), .mtvec(mtvec), .mstatus(mstatus),
        .mie(mie), .mip(mip), .irq_req(irq_req), .irq_vector(irq_vector)
    );

    always #5 clock = ~clock;

    // Reference architectural state
    logic [63:0] m_mepc, m_mcause, m_mtvec, m_mstatus, m_mie, m_mip;
    logic        m_req;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock)
        if (!reset && irq_take)
            assert (irq_req) else $error("protocol: irq_take issued while irq_req low");

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mepc", mepc, e.mepc);
                chk("mcause", mcause, e.mcause);
                chk("mtvec", mtvec, e.mtvec);
                chk("mstatus", mstatus, e.mstatus);
                chk("mie", mie, e.mie);
                chk("mip", mip, e.mip);
                chk("irq_req", {63'd0, irq_req}, {63'd0, e.req});
                chk("irq_vector", irq_vector, e.mtvec);
            end
        end
    end

    // Apply current inputs for one clock: advance the model, queue its state, wait a cycle.
    task automatic cycle();
        logic [63:0] n_mepc, n_mcause, n_mtvec, n_mstatus, n_mie, n_mip;
        logic        n_req, pend, we;
        if (reset) begin
            n_mepc = 0; n_mcause = 0; n_mtvec = 0; n_mie = 0; n_mip = 0;
            n_mstatus = MST_RST; n_req = 0;
        end else begin
            we        = wb_valid;
            pend      = m_mstatus[3] && m_mie[7] && m_mip[7];
            n_req     = pend && !irq_take;
            n_mepc    = (we && wbcsren[0]) ? (wbmepc & ~64'h1)    : m_mepc;
            n_mcause  = (we && wbcsren[1]) ? wbmcause             : m_mcause;
            n_mtvec   = (we && wbcsren[2]) ? (wbmtvec & ~64'h3)   : m_mtvec;
            n_mstatus = (we && wbcsren[3]) ? wbmstatus            : m_mstatus;
            n_mie     = (we && wbcsren[4]) ? wbmie                : m_mie;
            n_mip     = ((we && wbcsren[5]) ? wbmip : m_mip) & ~64'h80;
            if (timer_irq) n_mip = n_mip | 64'h80;
            if (irq_take) begin
                n_mepc    = irq_pc & ~64'h1;
                n_mcause  = 64'h8000_0000_0000_0007;
                n_mstatus = (m_mstatus & ~64'h1888) | 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
            end
        end
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtvec = n_mtvec;
        m_mstatus = n_mstatus; m_mie = n_mie; m_mip = n_mip; m_req = n_req;
        q.push_back('{m_mepc, m_mcause, m_mtvec, m_mstatus, m_mie, m_mip, m_req});
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 0; wb_valid = 0; wbcsren = 0; irq_take = 0;
    endtask

    task automatic wr(input logic [7:0] en, input logic [63:0] d);
        idle();
        wb_valid = 1; wbcsren = en;
        wbmepc = d; wbmcause = d; wbmtvec = d; wbmstatus = d; wbmie = d; wbmip = d;
    endtask

    task automatic wait_req();
        idle();
        for (int i = 0; i < 8 && !m_req; i++) cycle();
    endtask

    initial begin
        m_mepc = 0; m_mcause = 0; m_mtvec = 0; m_mstatus = MST_RST;
        m_mie = 0; m_mip = 0; m_req = 0;

        // Reset values
        reset = 1; cycle(); cycle();
        idle(); cycle();

        // ecall-style multi-register write
        idle(); wb_valid = 1; wbcsren = 8'b0000_1011;
        wbmepc = 64'h8000_0104; wbmcause = 64'hb; wbmstatus = 64'h0a_0000_1880;
        cycle();

        // Masking and valid gating
        wr(8'h04, 64'h8000_0007); cycle();
        wr(8'h20, 64'hFFFF); cycle();
        wr(8'h20, 64'h0); wb_valid = 0; cycle();
        wr(8'h01, 64'h8000_0333); cycle();

        // Interrupt flow: enable MIE + MTIE, raise the timer, take the request
        idle(); wb_valid = 1; wbcsren = 8'h18; wbmstatus = 64'h0a_0000_1888; wbmie = 64'h80;
        cycle();
        idle(); timer_irq = 1; cycle();
        wait_req();
        irq_take = 1; irq_pc = 64'h8000_0200; cycle();
        idle(); repeat (3) cycle();

        // Collision: re-enable MIE, then take with an overlapping mepc/mtvec write
        wr(8'h08, 64'h0a_0000_1888); cycle();
        wait_req();
        idle(); irq_take = 1; irq_pc = 64'h8000_0300; wb_valid = 1; wbcsren = 8'b0000_0101;
        wbmepc = 64'h1234; wbmtvec = 64'h8000_0100;
        cycle();
        idle(); cycle();

        // Timer drop while requesting clears irq_req without a take
        wr(8'h08, 64'h0a_0000_1888); cycle();
        wait_req();
        idle(); timer_irq = 0; cycle(); cycle(); cycle();

        // Reset while requesting, with a simultaneous take
        timer_irq = 1; cycle();
        wait_req();
        idle(); reset = 1; irq_take = 1; irq_pc = 64'h8000_0400; cycle();
        idle(); cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            reset     = ($urandom_range(0, 79) == 0);
            wb_valid  = $urandom_range(0, 1);
            wbcsren   = 8'($urandom);
            wbmepc    = {$urandom, $urandom};
            wbmcause  = {$urandom, $urandom};
            wbmtvec   = {$urandom, $urandom};
            wbmstatus = {$urandom, $urandom};
            wbmie     = {$urandom, $urandom};
            wbmip     = {$urandom, $urandom};
            irq_pc    = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) timer_irq = ~timer_irq;
            irq_take  = m_req && !reset && ($urandom_range(0, 2) == 0);
            cycle();
        end

        idle();
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
